// File: rtl/noc_pe_endpoint_pkg.sv
// Flit geometry and packing helpers shared by the PE endpoint and its bench.
// No logic; field offsets place payload low, dest x above it, dest y on top.
// Not applicable (types and constants only).
package noc_pe_endpoint_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int X_SIZE      = 2;
    localparam int Y_SIZE      = 2;
    localparam int TOTAL_WIDTH = DATA_WIDTH + X_SIZE + Y_SIZE;
    localparam int PAYLOAD_LSB = 0;
    localparam int X_LSB       = PAYLOAD_LSB + DATA_WIDTH;
    localparam int Y_LSB       = X_LSB + X_SIZE;

    typedef struct packed {
        logic [Y_SIZE-1:0]     y;
        logic [X_SIZE-1:0]     x;
        logic [DATA_WIDTH-1:0] payload;
    } flit_t;

    function automatic flit_t pack_flit(input logic [DATA_WIDTH-1:0] payload,
                                        input logic [X_SIZE-1:0]     x,
                                        input logic [Y_SIZE-1:0]     y);
        flit_t f;
        f.payload = payload;
        f.x       = x;
        f.y       = y;
        return f;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides.
// Latency: a push at edge N is visible at the head in cycle N+1.
// Backpressure: push_rdy is registered not-full; a same-cycle pop never raises it.
module noc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             push_rdy_q;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push_vld & push_rdy_q;
    assign do_pop   = pop_rdy & pop_vld;
    assign push_rdy = push_rdy_q;
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Ready is held low through the reset cycle and rises one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_rdy_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_nxt;
            push_rdy_q <= (count_nxt != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/noc_pe_endpoint.sv
// PE-side mesh endpoint: packs PE requests into flits, filters ejected flits by tile coordinate.
// Latency: one cycle each way (accept at edge N, valid in cycle N+1).
// Backpressure: readies are registered not-full of the TX/RX FIFOs; valids hold until accepted.
module noc_pe_endpoint
    import noc_pe_endpoint_pkg::*;
#(
    parameter int X_COORD  = 0,
    parameter int Y_COORD  = 0,
    parameter int TX_DEPTH = 2,
    parameter int RX_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_tx_valid,
    input  logic [DATA_WIDTH-1:0]  i_tx_data,
    input  logic [X_SIZE-1:0]      i_tx_dest_x,
    input  logic [Y_SIZE-1:0]      i_tx_dest_y,
    output logic                   o_tx_ready,
    output logic                   o_noc_valid,
    output logic [TOTAL_WIDTH-1:0] o_noc_data,
    input  logic                   i_noc_ready,
    input  logic                   i_noc_valid,
    input  logic [TOTAL_WIDTH-1:0] i_noc_data,
    output logic                   o_noc_ready,
    output logic                   o_rx_valid,
    output logic [DATA_WIDTH-1:0]  o_rx_data,
    input  logic                   i_rx_ready,
    output logic [15:0]            o_tx_count,
    output logic [15:0]            o_rx_count,
    output logic [7:0]             o_misroute_count
);

    localparam logic [X_SIZE-1:0] OWN_X = X_SIZE'(X_COORD);
    localparam logic [Y_SIZE-1:0] OWN_Y = Y_SIZE'(Y_COORD);

    flit_t tx_flit;
    flit_t rx_flit;
    logic  rx_match;
    logic  rx_accept;
    logic  tx_fire;
    logic  rx_fire;

    assign tx_flit   = pack_flit(i_tx_data, i_tx_dest_x, i_tx_dest_y);
    assign rx_flit   = flit_t'(i_noc_data);
    assign rx_match  = (rx_flit.x == OWN_X) && (rx_flit.y == OWN_Y);
    assign rx_accept = i_noc_valid & o_noc_ready;
    assign tx_fire   = o_noc_valid & i_noc_ready;
    assign rx_fire   = o_rx_valid & i_rx_ready;

    // Own-tile destinations are not short-circuited; the router loops them back.
    noc_sync_fifo #(
        .WIDTH (TOTAL_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (i_tx_valid),
        .push_dat (tx_flit),
        .push_rdy (o_tx_ready),
        .pop_vld  (o_noc_valid),
        .pop_dat  (o_noc_data),
        .pop_rdy  (i_noc_ready)
    );

    // Mismatched flits are still handshaken so they drain from the router.
    noc_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (i_noc_valid & rx_match),
        .push_dat (rx_flit.payload),
        .push_rdy (o_noc_ready),
        .pop_vld  (o_rx_valid),
        .pop_dat  (o_rx_data),
        .pop_rdy  (i_rx_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o_tx_count       <= '0;
            o_rx_count       <= '0;
            o_misroute_count <= '0;
        end else begin
            if (tx_fire) o_tx_count <= o_tx_count + 16'd1;
            if (rx_fire) o_rx_count <= o_rx_count + 16'd1;
            if (rx_accept && !rx_match && (o_misroute_count != 8'hFF)) begin
                o_misroute_count <= o_misroute_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_pe_endpoint.sv
// Bench for noc_pe_endpoint at tile (1,2): queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_noc_pe_endpoint;

    logic        clk;
    logic        rst;
    logic        i_tx_valid;
    logic [31:0] i_tx_data;
    logic [1:0]  i_tx_dest_x;
    logic [1:0]  i_tx_dest_y;
    logic        o_tx_ready;
    logic        o_noc_valid;
    logic [35:0] o_noc_data;
    logic        i_noc_ready;
    logic        i_noc_valid;
    logic [35:0] i_noc_data;
    logic        o_noc_ready;
    logic        o_rx_valid;
    logic [31:0] o_rx_data;
    logic        i_rx_ready;
    logic [15:0] o_tx_count;
    logic [15:0] o_rx_count;
    logic [7:0]  o_misroute_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    noc_pe_endpoint #(
        .X_COORD  (1),
        .Y_COORD  (2),
        .TX_DEPTH (2),
        .RX_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_tx_valid       (i_tx_valid),
        .i_tx_data        (i_tx_data),
        .i_tx_dest_x      (i_tx_dest_x),
        .i_tx_dest_y      (i_tx_dest_y),
        .o_tx_ready       (o_tx_ready),
        .o_noc_valid      (o_noc_valid),
        .o_noc_data       (o_noc_data),
        .i_noc_ready      (i_noc_ready),
        .i_noc_valid      (i_noc_valid),
        .i_noc_data       (i_noc_data),
        .o_noc_ready      (o_noc_ready),
        .o_rx_valid       (o_rx_valid),
        .o_rx_data        (o_rx_data),
        .i_rx_ready       (i_rx_ready),
        .o_tx_count       (o_tx_count),
        .o_rx_count       (o_rx_count),
        .o_misroute_count (o_misroute_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffers as queues, capacity 2 (TX) / 4 (RX), readies reflect
    // occupancy after the previous edge.
    logic [35:0] m_txq[$];
    logic [31:0] m_rxq[$];
    logic [15:0] m_tx_cnt;
    logic [15:0] m_rx_cnt;
    logic [7:0]  m_mis;
    bit          m_tx_rdy;
    bit          m_rx_rdy;
    bit          tx_pop, tx_push, rx_pop, rx_acc;
    logic [35:0] tmp_flit;
    logic [31:0] tmp_pay;

    always @(posedge clk) begin
        if (rst) begin
            m_txq.delete();
            m_rxq.delete();
            m_tx_cnt = 0;
            m_rx_cnt = 0;
            m_mis    = 0;
            m_tx_rdy = 0;
            m_rx_rdy = 0;
        end else begin
            tx_pop  = (m_txq.size() != 0) && i_noc_ready;
            tx_push = i_tx_valid && m_tx_rdy;
            rx_pop  = (m_rxq.size() != 0) && i_rx_ready;
            rx_acc  = i_noc_valid && m_rx_rdy;
            if (tx_pop) begin
                tmp_flit = m_txq.pop_front();
                m_tx_cnt = m_tx_cnt + 16'd1;
            end
            if (tx_push) m_txq.push_back({i_tx_dest_y, i_tx_dest_x, i_tx_data});
            if (rx_pop) begin
                tmp_pay  = m_rxq.pop_front();
                m_rx_cnt = m_rx_cnt + 16'd1;
            end
            if (rx_acc) begin
                if (i_noc_data[33:32] == 2'd1 && i_noc_data[35:34] == 2'd2)
                    m_rxq.push_back(i_noc_data[31:0]);
                else if (m_mis != 8'd255)
                    m_mis = m_mis + 8'd1;
            end
            m_tx_rdy = m_txq.size() < 2;
            m_rx_rdy = m_rxq.size() < 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("noc_valid", o_noc_valid, m_txq.size() != 0);
            if (m_txq.size() != 0) check("noc_data", o_noc_data, m_txq[0]);
            check("rx_valid", o_rx_valid, m_rxq.size() != 0);
            if (m_rxq.size() != 0) check("rx_data", o_rx_data, m_rxq[0]);
            check("tx_ready", o_tx_ready, m_tx_rdy);
            check("noc_ready", o_noc_ready, m_rx_rdy);
            check("tx_count", o_tx_count, m_tx_cnt);
            check("rx_count", o_rx_count, m_rx_cnt);
            check("misroute_count", o_misroute_count, m_mis);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst = 1; i_tx_valid = 0; i_tx_data = 0; i_tx_dest_x = 0; i_tx_dest_y = 0;
        i_noc_ready = 0; i_noc_valid = 0; i_noc_data = 0; i_rx_ready = 0;

        // reset then idle
        tick(1);
        chk_en = 1;
        tick(2);
        check("lit_rst_tx_ready", o_tx_ready, 0);
        check("lit_rst_noc_ready", o_noc_ready, 0);
        check("lit_rst_noc_valid", o_noc_valid, 0);
        rst = 0;
        tick(1);
        check("lit_rel_tx_ready", o_tx_ready, 1);
        check("lit_rel_noc_ready", o_noc_ready, 1);
        check("lit_rel_tx_count", o_tx_count, 0);

        // TX single to (3,0)
        i_noc_ready = 1;
        i_tx_valid = 1; i_tx_data = 32'hDEADBEEF; i_tx_dest_x = 2'd3; i_tx_dest_y = 2'd0;
        tick(1);
        i_tx_valid = 0;
        check("lit_tx_single_valid", o_noc_valid, 1);
        check("lit_tx_single_data", o_noc_data, 36'h3DEADBEEF);
        tick(1);
        check("lit_tx_single_gone", o_noc_valid, 0);
        check("lit_tx_single_count", o_tx_count, 1);

        // TX backpressure: third request refused
        i_noc_ready = 0;
        for (int i = 0; i < 3; i++) begin
            i_tx_valid = 1; i_tx_data = 32'hA0 + i; i_tx_dest_x = 2'd1; i_tx_dest_y = 2'd2;
            tick(1);
        end
        check("lit_bp_tx_ready", o_tx_ready, 0);
        i_tx_valid = 0;
        tick(2);
        check("lit_bp_head", o_noc_data, 36'h9000000A0);
        i_noc_ready = 1;
        tick(1);
        check("lit_bp_second", o_noc_data, 36'h9000000A1);
        tick(1);
        check("lit_bp_count", o_tx_count, 3);
        check("lit_bp_empty", o_noc_valid, 0);

        // TX streaming at full rate, including own-tile destination
        for (int i = 0; i < 6; i++) begin
            i_tx_valid = 1; i_tx_data = 32'h1000 * (i + 1);
            i_tx_dest_x = 2'(i); i_tx_dest_y = 2'(3 - i);
            tick(1);
        end
        i_tx_valid = 0;
        tick(3);
        check("lit_stream_count", o_tx_count, 9);

        // RX matched flits with PE stalled: 4 of 5 accepted
        i_noc_valid = 1; i_noc_data = 36'h900000055;
        tick(5);
        i_noc_valid = 0;
        check("lit_rx_full", o_noc_ready, 0);
        check("lit_rx_head", o_rx_data, 32'h55);
        i_rx_ready = 1;
        tick(5);
        check("lit_rx_count", o_rx_count, 4);
        check("lit_rx_empty", o_rx_valid, 0);

        // misrouted flit (x=0), then saturation
        i_noc_valid = 1; i_noc_data = 36'h800000077;
        tick(1);
        i_noc_valid = 0;
        tick(1);
        check("lit_mis_one", o_misroute_count, 1);
        check("lit_mis_not_delivered", o_rx_valid, 0);
        i_noc_valid = 1;
        tick(300);
        i_noc_valid = 0;
        tick(1);
        check("lit_mis_sat", o_misroute_count, 255);

        // reset with buffered flits in both directions
        i_noc_ready = 0; i_rx_ready = 0;
        i_tx_valid = 1; i_tx_data = 32'h11111111; i_tx_dest_x = 2'd0; i_tx_dest_y = 2'd1;
        i_noc_valid = 1; i_noc_data = 36'h900000099;
        tick(2);
        i_tx_valid = 0;
        tick(1);
        i_noc_valid = 0;
        tick(1);
        check("lit_pre_rst_tx_full", o_tx_ready, 0);
        rst = 1;
        tick(1);
        check("lit_mid_rst_noc_valid", o_noc_valid, 0);
        check("lit_mid_rst_rx_valid", o_rx_valid, 0);
        check("lit_mid_rst_tx_count", o_tx_count, 0);
        check("lit_mid_rst_rx_count", o_rx_count, 0);
        check("lit_mid_rst_mis", o_misroute_count, 0);
        rst = 0;
        i_noc_ready = 1; i_rx_ready = 1;
        tick(5);
        check("lit_post_rst_noc_valid", o_noc_valid, 0);
        check("lit_post_rst_rx_valid", o_rx_valid, 0);
        check("lit_post_rst_tx_count", o_tx_count, 0);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
